// File: rtl/aes256_key_expand_if.sv
// AES-256 key expansion bus.
//   master : key schedule consumer (drives start/key_in/rd_round, reads status and round_key)
//   slave  : the key expander itself
// Signals:
//   start       1-cycle pulse that latches key_in and begins expansion
//   key_in      256-bit cipher key, key_in[255:224] = w0
//   busy        expansion in progress
//   keys_valid  all 15 round keys complete
//   rk_avail    number of complete round keys, 0..15
//   rd_round    round index to read, 0..14
//   round_key   combinational read of round rd_round, w[4r] in [127:96]
interface aes256_key_expand_if;
  logic         start;
  logic [255:0] key_in;
  logic         busy;
  logic         keys_valid;
  logic [3:0]   rk_avail;
  logic [3:0]   rd_round;
  logic [127:0] round_key;

  modport master (
    output start,
    output key_in,
    output rd_round,
    input  busy,
    input  keys_valid,
    input  rk_avail,
    input  round_key
  );

  modport slave (
    input  start,
    input  key_in,
    input  rd_round,
    output busy,
    output keys_valid,
    output rk_avail,
    output round_key
  );
endinterface

// File: rtl/aes256_key_expand.sv
// AES-256 key expander.
// Expands a 256-bit key into 60 schedule words (15 round keys), one word per clock, into a
// word store. Round keys become readable as soon as their four words are written, so the
// cipher core can start on early rounds while later ones are still being produced.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-high reset
//   bus  : aes256_key_expand_if.slave (start/key_in in, status out, rd_round/round_key read port)
module aes256_key_expand #(
  parameter int unsigned NR = 14,
  parameter int unsigned NK = 8
) (
  input logic                clk,
  input logic                rst,
  aes256_key_expand_if.slave bus
);

  localparam int unsigned NumWords = 4 * (NR + 1);
  localparam int unsigned IdxW     = $clog2(NumWords);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StExpand = 2'd1;
  localparam logic [1:0] StDone   = 2'd2;

  // Forward AES S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SboxTable = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    // Byte b lives at bit offset (255-b)*8, and 255-b == ~b for 8-bit b.
    return SboxTable[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  logic [1:0]      state_q, state_d;
  logic [IdxW-1:0] word_idx_q, word_idx_d;
  logic            busy_q, busy_d;
  logic            keys_valid_q, keys_valid_d;
  logic [3:0]      rk_avail_q, rk_avail_d;
  logic            load_key;
  logic            store_we;

  // Word store is deliberately not reset; reads are masked by rk_avail instead.
  logic [31:0]     store_q [NumWords];

  logic [31:0]     prev_word;
  logic [31:0]     back_word;
  logic [31:0]     temp;
  logic [31:0]     new_word;
  logic [7:0]      rcon;

  // ---------------------------------------------------------------------------
  // Schedule word datapath: w[i] = w[i-8] ^ f(w[i-1])
  // ---------------------------------------------------------------------------
  assign prev_word = store_q[word_idx_q - IdxW'(1)];
  assign back_word = store_q[word_idx_q - IdxW'(NK)];

  // Rcon index is i/8, which is 1..7 over the words that need it.
  always_comb begin
    rcon = 8'h00;
    case (word_idx_q[5:3])
      3'd1:    rcon = 8'h01;
      3'd2:    rcon = 8'h02;
      3'd3:    rcon = 8'h04;
      3'd4:    rcon = 8'h08;
      3'd5:    rcon = 8'h10;
      3'd6:    rcon = 8'h20;
      3'd7:    rcon = 8'h40;
      default: rcon = 8'h00;
    endcase
  end

  always_comb begin
    temp = prev_word;
    if (word_idx_q[2:0] == 3'd0) begin
      temp = sub_word({prev_word[23:0], prev_word[31:24]}) ^ {rcon, 24'h000000};
    end else if (word_idx_q[2:0] == 3'd4) begin
      temp = sub_word(prev_word);
    end
  end

  assign new_word = back_word ^ temp;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    word_idx_d   = word_idx_q;
    busy_d       = busy_q;
    keys_valid_d = keys_valid_q;
    rk_avail_d   = rk_avail_q;
    load_key     = 1'b0;
    store_we     = 1'b0;

    case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d      = StExpand;
          word_idx_d   = IdxW'(NK);
          busy_d       = 1'b1;
          keys_valid_d = 1'b0;
          // Rounds 0 and 1 are the raw key words, available immediately.
          rk_avail_d   = 4'd2;
          load_key     = 1'b1;
        end
      end
      StExpand: begin
        // start is ignored here, including on the final edge.
        store_we   = 1'b1;
        word_idx_d = word_idx_q + IdxW'(1);
        if (word_idx_q[1:0] == 2'b11 && rk_avail_q != 4'd15) begin
          rk_avail_d = rk_avail_q + 4'd1;
        end
        if (word_idx_q == IdxW'(NumWords - 1)) begin
          state_d      = StDone;
          word_idx_d   = word_idx_q;
          busy_d       = 1'b0;
          keys_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      word_idx_q   <= '0;
      busy_q       <= 1'b0;
      keys_valid_q <= 1'b0;
      rk_avail_q   <= 4'd0;
    end else begin
      state_q      <= state_d;
      word_idx_q   <= word_idx_d;
      busy_q       <= busy_d;
      keys_valid_q <= keys_valid_d;
      rk_avail_q   <= rk_avail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load_key) begin
      for (int k = 0; k < NK; k++) begin
        store_q[k] <= bus.key_in[255 - 32 * k -: 32];
      end
    end else if (store_we) begin
      store_q[word_idx_q] <= new_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs and read port
  // ---------------------------------------------------------------------------
  assign bus.busy       = busy_q;
  assign bus.keys_valid = keys_valid_q;
  assign bus.rk_avail   = rk_avail_q;

  logic [IdxW-1:0] rd_base;
  assign rd_base = {bus.rd_round, 2'b00};

  always_comb begin
    bus.round_key = '0;
    if (bus.rd_round < rk_avail_q && bus.rd_round <= 4'(NR)) begin
      bus.round_key = {store_q[rd_base],          store_q[rd_base | IdxW'(1)],
                       store_q[rd_base | IdxW'(2)], store_q[rd_base | IdxW'(3)]};
    end
  end

endmodule

// File: tb/tb_aes256_key_expand.sv
module tb_aes256_key_expand;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  aes256_key_expand_if bus ();

  aes256_key_expand dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Reference model: S-box built from GF(2^8) inverse + affine map, Rcon by xtime
  // ---------------------------------------------------------------------------
  logic [7:0]  sbox_m [256];
  logic [31:0] ref_w  [60];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
    return (v << s) | (v >> (8 - s));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] a;
    for (int v = 0; v < 256; v++) begin
      a   = 8'(v);
      inv = 8'h01;
      for (int e = 0; e < 254; e++) inv = gmul(inv, a);
      if (v == 0) inv = 8'h00;
      sbox_m[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub32(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  task automatic compute_ref(input logic [255:0] key);
    logic [31:0] t;
    logic [7:0]  rc;
    for (int k = 0; k < 8; k++) ref_w[k] = key[255 - 32 * k -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = ref_w[i - 1];
      if (i % 8 == 0) begin
        t  = sub32({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        t = sub32(t);
      end
      ref_w[i] = ref_w[i - 8] ^ t;
    end
  endtask

  function automatic logic [127:0] exp_rk(input int r, input int avail);
    if (r < avail && r <= 14)
      return {ref_w[4 * r], ref_w[4 * r + 1], ref_w[4 * r + 2], ref_w[4 * r + 3]};
    return 128'h0;
  endfunction

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int j = 0; j < 8; j++) k[32 * j +: 32] = $urandom;
    return k;
  endfunction

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pulse start with key, then watch every cycle up to one past completion.
  // If pulse_at > 0, start is re-pulsed so it is sampled on edge T<pulse_at> with other_key.
  task automatic watch_expansion(input string name, input logic [255:0] key, input int pulse_at,
                                 input logic [255:0] other_key);
    int rk_exp;
    int rd;
    compute_ref(key);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.key_in = key;
    @(negedge clk);
    bus.start = 1'b0;
    for (int n = 0; n <= 53; n++) begin
      rk_exp = (2 + n / 4 > 15) ? 15 : 2 + n / 4;
      check($sformatf("%s rk_avail@%0d", name, n), 128'(bus.rk_avail), 128'(rk_exp));
      check($sformatf("%s busy@%0d", name, n), 128'(bus.busy), 128'(n < 52));
      check($sformatf("%s keys_valid@%0d", name, n), 128'(bus.keys_valid), 128'(n >= 52));
      rd = (n == 4 || n == 8) ? 3 : int'($urandom_range(0, 15));
      bus.rd_round = 4'(rd);
      #1;
      check($sformatf("%s round_key[%0d]@%0d", name, rd, n), bus.round_key, exp_rk(rd, rk_exp));
      if (pulse_at > 0 && n + 1 == pulse_at) begin
        bus.start  = 1'b1;
        bus.key_in = other_key;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  task automatic check_all_rounds(input string name);
    for (int r = 0; r < 16; r++) begin
      bus.rd_round = 4'(r);
      #1;
      check($sformatf("%s final round_key[%0d]", name, r), bus.round_key, exp_rk(r, 15));
    end
  endtask

  task automatic check_literal(input string name, input int r, input logic [127:0] exp);
    bus.rd_round = 4'(r);
    #1;
    check(name, bus.round_key, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [255:0] key_c;
    logic [255:0] key_seq;
    n_cmp        = 0;
    n_fail       = 0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.key_in   = '0;
    bus.rd_round = 4'd0;
    build_sbox();

    // Reset state
    #12;
    check("reset busy", 128'(bus.busy), 128'h0);
    check("reset keys_valid", 128'(bus.keys_valid), 128'h0);
    check("reset rk_avail", 128'(bus.rk_avail), 128'h0);
    check("reset round_key", bus.round_key, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle busy", 128'(bus.busy), 128'h0);
    check("idle rk_avail", 128'(bus.rk_avail), 128'h0);

    // FIPS-197 A.3 key with an ignored start re-pulse at T20
    watch_expansion("fips", 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                    20, rand_key());
    check_all_rounds("fips");
    check_literal("fips round2", 2, 128'h9ba354118e6925afa51a8b5f2067fcde);
    check_literal("fips round14", 14, 128'hfe4890d1e6188d0b046df344706c631e);

    // Random key from DONE, start coincident with completion at T52
    watch_expansion("rand_b", rand_key(), 52, rand_key());
    check_all_rounds("rand_b");

    // Asynchronous reset mid-expansion
    key_c = rand_key();
    @(negedge clk);
    bus.start  = 1'b1;
    bus.key_in = key_c;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (29) @(negedge clk);
    bus.rd_round = 4'd0;
    #2;
    rst = 1'b1;
    #1;
    check("abort busy", 128'(bus.busy), 128'h0);
    check("abort keys_valid", 128'(bus.keys_valid), 128'h0);
    check("abort rk_avail", 128'(bus.rk_avail), 128'h0);
    check("abort round_key", bus.round_key, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post-abort busy", 128'(bus.busy), 128'h0);
    check("post-abort rk_avail", 128'(bus.rk_avail), 128'h0);

    // Restart from IDLE after the abort
    watch_expansion("restart", key_c, 0, '0);
    check_all_rounds("restart");

    // Back-to-back from DONE with the sequential key 00..1f
    for (int j = 0; j < 32; j++) key_seq[255 - 8 * j -: 8] = 8'(j);
    watch_expansion("seq", key_seq, 0, '0);
    check_all_rounds("seq");
    check_literal("seq round14", 14, 128'h24fc79ccbf0979e9371ac23c6d68de36);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
